// File: rtl/test_supervisor.sv
// -----------------------------------------------------------------------------
// test_supervisor
//
// Purpose: sequences one test run of a system under test (SUT). After power-on
// reset it holds the SUT in reset for RESET_CYCLES cycles, then lets it run and
// watches for either a program-complete indication (halt_req), a trap on any
// channel, or expiry of the RUN cycle budget. A trap opens a grace window so
// follow-on traps are still recorded. The final verdict (pass/fail) is held in
// DONE until the next power-on reset.
//
// Ports:
//   clk               in   1          system clock, rising-edge active
//   power_on_reset_n  in   1          asynchronous active-low reset
//   trap              in   NUM_TRAPS  per-channel trap request
//   halt_req          in   1          program-complete indication
//   sys_reset         out  1          active-high reset to the SUT
//   state             out  2          0=RESET_HOLD 1=RUN 2=GRACE 3=DONE
//   finished          out  1          high while in DONE
//   pass              out  1          run ended by halt_req without trap
//   fail              out  1          run ended by trap or timeout
//   timeout           out  1          sticky: RUN budget expired
//   trap_latched      out  NUM_TRAPS  sticky per-channel trap record
//   first_trap_id     out  4          lowest channel of the first trapping cycle
//   cycle_count       out  CNT_W      cycles spent in RUN, saturating
// -----------------------------------------------------------------------------
module test_supervisor #(
    parameter int NUM_TRAPS      = 1,
    parameter int RESET_CYCLES   = 5,
    parameter int TIMEOUT_CYCLES = 2045,
    parameter int GRACE_CYCLES   = 5,
    parameter int CNT_W          = 16
) (
    input  logic                 clk,
    input  logic                 power_on_reset_n,
    input  logic [NUM_TRAPS-1:0] trap,
    input  logic                 halt_req,
    output logic                 sys_reset,
    output logic [1:0]           state,
    output logic                 finished,
    output logic                 pass,
    output logic                 fail,
    output logic                 timeout,
    output logic [NUM_TRAPS-1:0] trap_latched,
    output logic [3:0]           first_trap_id,
    output logic [CNT_W-1:0]     cycle_count
);

    typedef enum logic [1:0] {
        ST_RESET_HOLD = 2'd0,
        ST_RUN        = 2'd1,
        ST_GRACE      = 2'd2,
        ST_DONE       = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] RESET_LD   = CNT_W'(RESET_CYCLES);
    localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] GRACE_LD   = CNT_W'(GRACE_CYCLES);
    localparam bit               GRACE_EN   = (GRACE_CYCLES != 0);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;          // shared reset-hold / grace down-counter
    logic [CNT_W-1:0]     cycle_q, cycle_d;
    logic [CNT_W-1:0]     cycle_inc_s;
    logic [NUM_TRAPS-1:0] latched_q, latched_d;
    logic [3:0]           id_q, id_d;
    logic                 timeout_q, timeout_d;
    logic                 pass_q, pass_d;
    logic                 fail_q, fail_d;
    logic                 finished_q, finished_d;
    logic                 sys_reset_q, sys_reset_d;

    // Index of the lowest set bit; the scan runs high-to-low so the lowest wins.
    function automatic logic [3:0] lowest_idx(input logic [NUM_TRAPS-1:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = NUM_TRAPS - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = 4'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Next-state, counter and verdict logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cycle_d     = cycle_q;
        latched_d   = latched_q;
        id_d        = id_q;
        timeout_d   = timeout_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        cycle_inc_s = (cycle_q == CNT_MAX) ? cycle_q : (cycle_q + CNT_ONE);

        case (state_q)
            ST_RESET_HOLD: begin
                // Inputs are deliberately ignored while the SUT is in reset.
                if (cnt_q <= CNT_ONE) begin
                    state_d = ST_RUN;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_RUN: begin
                // The count includes the cycle in which RUN is left, so a halt
                // in RUN cycle N leaves cycle_count == N.
                cycle_d = cycle_inc_s;
                if (|trap) begin
                    // Trap beats a simultaneous halt_req or timeout.
                    latched_d = latched_q | trap;
                    id_d      = lowest_idx(trap);
                    if (GRACE_EN) begin
                        state_d = ST_GRACE;
                        cnt_d   = GRACE_LD;
                    end else begin
                        state_d = ST_DONE;
                        fail_d  = 1'b1;
                    end
                end else if (halt_req) begin
                    state_d = ST_DONE;
                    pass_d  = 1'b1;
                end else if (cycle_inc_s == TIMEOUT_LD) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                    fail_d    = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_GRACE: begin
                // Late traps are still recorded; halt_req has no meaning here.
                latched_d = latched_q | trap;
                if (cnt_q <= CNT_ONE) begin
                    state_d = ST_DONE;
                    fail_d  = 1'b1;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_RESET_HOLD;
                cnt_d   = RESET_LD;
            end
        endcase

        finished_d  = (state_d == ST_DONE);
        sys_reset_d = (state_d == ST_RESET_HOLD);
    end

    // State and record registers; reset restarts the whole sequence.
    always_ff @(posedge clk or negedge power_on_reset_n) begin
        if (!power_on_reset_n) begin
            state_q     <= ST_RESET_HOLD;
            cnt_q       <= RESET_LD;
            cycle_q     <= CNT_ZERO;
            latched_q   <= {NUM_TRAPS{1'b0}};
            id_q        <= 4'd0;
            timeout_q   <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            finished_q  <= 1'b0;
            sys_reset_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cycle_q     <= cycle_d;
            latched_q   <= latched_d;
            id_q        <= id_d;
            timeout_q   <= timeout_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            finished_q  <= finished_d;
            sys_reset_q <= sys_reset_d;
        end
    end

    assign state         = state_q;
    assign sys_reset     = sys_reset_q;
    assign finished      = finished_q;
    assign pass          = pass_q;
    assign fail          = fail_q;
    assign timeout       = timeout_q;
    assign trap_latched  = latched_q;
    assign first_trap_id = id_q;
    assign cycle_count   = cycle_q;

endmodule

// File: tb/tb_test_supervisor.sv
// -----------------------------------------------------------------------------
// tb_test_supervisor
//
// Directed bench for test_supervisor with NUM_TRAPS=4 and default timing
// parameters (RESET_CYCLES=5, TIMEOUT_CYCLES=2045, GRACE_CYCLES=5, CNT_W=16).
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_test_supervisor;

    logic        clk;
    logic        por_n;
    logic [3:0]  trap;
    logic        halt_req;
    logic        sys_reset;
    logic [1:0]  state;
    logic        finished;
    logic        pass;
    logic        fail;
    logic        timeout;
    logic [3:0]  trap_latched;
    logic [3:0]  first_trap_id;
    logic [15:0] cycle_count;

    int tests_run;
    int tests_failed;

    test_supervisor #(
        .NUM_TRAPS      (4),
        .RESET_CYCLES   (5),
        .TIMEOUT_CYCLES (2045),
        .GRACE_CYCLES   (5),
        .CNT_W          (16)
    ) dut (
        .clk              (clk),
        .power_on_reset_n (por_n),
        .trap             (trap),
        .halt_req         (halt_req),
        .sys_reset        (sys_reset),
        .state            (state),
        .finished         (finished),
        .pass             (pass),
        .fail             (fail),
        .timeout          (timeout),
        .trap_latched     (trap_latched),
        .first_trap_id    (first_trap_id),
        .cycle_count      (cycle_count)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        por_n    = 1'b0;
        trap     = 4'd0;
        halt_req = 1'b0;
        tick(2);
    endtask

    // Release reset and count cycles with sys_reset high; ends in RUN cycle 1.
    task automatic release_reset(input bit noisy, output int n);
        n     = 0;
        por_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (sys_reset !== 1'b1) break;
            n++;
            trap     = noisy ? 4'hF : 4'h0;
            halt_req = noisy;
            @(negedge clk);
        end
        trap     = 4'd0;
        halt_req = 1'b0;
    endtask

    // Advance until DONE; returns number of edges taken (limit on expiry).
    task automatic wait_done(input int limit, output int n);
        n = 0;
        while (state !== 2'd3 && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    int n;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        por_n        = 1'b0;
        trap         = 4'd0;
        halt_req     = 1'b0;
        tick(2);

        // Reset values.
        chk("rst_state",     state, 2'd0);
        chk("rst_sys_reset", sys_reset, 1'b1);
        chk("rst_finished",  finished, 1'b0);
        chk("rst_pass",      pass, 1'b0);
        chk("rst_fail",      fail, 1'b0);
        chk("rst_timeout",   timeout, 1'b0);
        chk("rst_latched",   trap_latched, 4'h0);
        chk("rst_id",        first_trap_id, 4'h0);
        chk("rst_count",     cycle_count, 16'd0);

        // Halt at RUN cycle 100, with noise on inputs during reset hold.
        release_reset(1'b1, n);
        chk("A_hold_cycles", n, 5);
        chk("A_run_state",   state, 2'd1);
        chk("A_run_latched", trap_latched, 4'h0);
        chk("A_run_count",   cycle_count, 16'd0);
        chk("A_run_sysrst",  sys_reset, 1'b0);
        tick(99);
        halt_req = 1'b1;
        tick(1);
        halt_req = 1'b0;
        chk("A_done_state", state, 2'd3);
        chk("A_finished",   finished, 1'b1);
        chk("A_pass",       pass, 1'b1);
        chk("A_fail",       fail, 1'b0);
        chk("A_count",      cycle_count, 16'd100);
        chk("A_timeout",    timeout, 1'b0);
        trap = 4'hF;
        tick(3);
        trap = 4'h0;
        chk("A_frozen_latched", trap_latched, 4'h0);
        chk("A_frozen_pass",    pass, 1'b1);
        chk("A_frozen_count",   cycle_count, 16'd100);
        chk("A_frozen_state",   state, 2'd3);

        // Two trap cycles, grace window of 5 cycles.
        do_reset();
        release_reset(1'b0, n);
        chk("B_hold_cycles", n, 5);
        tick(9);
        trap = 4'b0110;
        tick(1);
        chk("B_grace_state", state, 2'd2);
        trap = 4'b1000;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            n++;
            trap = 4'b0000;
            if (state === 2'd3) break;
        end
        chk("B_grace_len", n, 5);
        chk("B_id",        first_trap_id, 4'd1);
        chk("B_latched",   trap_latched, 4'b1110);
        chk("B_fail",      fail, 1'b1);
        chk("B_pass",      pass, 1'b0);
        chk("B_count",     cycle_count, 16'd10);
        chk("B_finished",  finished, 1'b1);

        // Trap and halt in the same RUN cycle: trap wins.
        do_reset();
        release_reset(1'b0, n);
        tick(2);
        trap     = 4'b0001;
        halt_req = 1'b1;
        tick(1);
        trap     = 4'b0000;
        halt_req = 1'b0;
        chk("D_grace_state", state, 2'd2);
        wait_done(20, n);
        chk("D_done_state", state, 2'd3);
        chk("D_fail",       fail, 1'b1);
        chk("D_pass",       pass, 1'b0);
        chk("D_latched",    trap_latched, 4'b0001);
        chk("D_count",      cycle_count, 16'd3);

        // Reset asserted mid-GRACE, then full sequence repeats.
        do_reset();
        release_reset(1'b0, n);
        tick(4);
        trap = 4'b0100;
        tick(1);
        trap = 4'b0000;
        tick(2);
        chk("C_mid_grace", state, 2'd2);
        chk("C_mid_id",    first_trap_id, 4'd2);
        #2;
        por_n = 1'b0;
        #1;
        chk("C_async_state",   state, 2'd0);
        chk("C_async_sysrst",  sys_reset, 1'b1);
        chk("C_async_latched", trap_latched, 4'h0);
        chk("C_async_id",      first_trap_id, 4'h0);
        chk("C_async_count",   cycle_count, 16'd0);
        chk("C_async_fail",    fail, 1'b0);
        tick(2);
        release_reset(1'b0, n);
        chk("C_rerun_hold", n, 5);
        halt_req = 1'b1;
        tick(1);
        halt_req = 1'b0;
        chk("C_rerun_pass",  pass, 1'b1);
        chk("C_rerun_count", cycle_count, 16'd1);

        // Timeout with no trap or halt.
        do_reset();
        release_reset(1'b0, n);
        wait_done(3000, n);
        chk("E_edges",   n, 2045);
        chk("E_state",   state, 2'd3);
        chk("E_count",   cycle_count, 16'd2045);
        chk("E_timeout", timeout, 1'b1);
        chk("E_fail",    fail, 1'b1);
        chk("E_pass",    pass, 1'b0);

        // Halt in the timeout cycle takes priority.
        do_reset();
        release_reset(1'b0, n);
        tick(2044);
        chk("F_pre_state", state, 2'd1);
        chk("F_pre_count", cycle_count, 16'd2044);
        halt_req = 1'b1;
        tick(1);
        halt_req = 1'b0;
        chk("F_state",   state, 2'd3);
        chk("F_pass",    pass, 1'b1);
        chk("F_fail",    fail, 1'b0);
        chk("F_timeout", timeout, 1'b0);
        chk("F_count",   cycle_count, 16'd2045);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
